// File: rtl/fifo_drain_ctrl.sv
// fifo_drain_ctrl: read-side controller for the synchronous FIFO.
// Optional rd_count accept counter is enabled by defining FIFO_DRAIN_CNT_EN.

module fifo_drain_ctrl #(
    parameter int WIDTH = 8,
    parameter int BURST = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             fifo_empty,
    input  logic [WIDTH-1:0] fifo_data,
    output logic             fifo_rd,
    output logic [WIDTH-1:0] m_data,
    output logic             m_valid,
    output logic             m_last,
    input  logic             m_ready,
    output logic             busy
`ifdef FIFO_DRAIN_CNT_EN
    ,
    output logic [CNT_W-1:0] rd_count
`endif
);

    localparam int BW = (BURST > 1) ? $clog2(BURST) : 1;
    localparam logic [BW-1:0] LAST_BEAT = BW'(BURST - 1);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        LATCH,
        SPACE
    } state_t;

    state_t state;

    logic [WIDTH-1:0] buf_data [2];
    logic [1:0]       buf_last;
    logic             head;
    logic             tail;
    logic [1:0]       occ;
    logic [BW-1:0]    beat_cnt;

    logic             push;
    logic             pop;
    logic             inflight;
    logic             can_issue;
    logic [2:0]       committed;

    assign inflight  = (state == ISSUE) || (state == LATCH);
    assign push      = (state == LATCH);
    assign pop       = m_valid && m_ready;
    assign committed = {1'b0, occ} + {2'b00, inflight};
    assign can_issue = enable && !fifo_empty && (committed < 3'd2);

    assign m_valid = (occ != 2'd0);
    assign m_data  = buf_data[head];
    assign m_last  = buf_last[head];
    assign busy    = (state != IDLE) || (occ != 2'd0);

    // Read sequencer: fixed 4-cycle loop so a lagging empty flag is safe.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            fifo_rd <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (can_issue) begin
                        state   <= ISSUE;
                        fifo_rd <= 1'b1;
                    end else begin
                        fifo_rd <= 1'b0;
                    end
                end
                ISSUE: begin
                    state   <= LATCH;
                    fifo_rd <= 1'b0;
                end
                LATCH: begin
                    state   <= SPACE;
                    fifo_rd <= 1'b0;
                end
                SPACE: begin
                    state   <= IDLE;
                    fifo_rd <= 1'b0;
                end
                default: begin
                    state   <= IDLE;
                    fifo_rd <= 1'b0;
                end
            endcase
        end
    end

    // Two-entry output buffer: push at LATCH, pop on accepted handshake.
    always_ff @(posedge clk) begin
        if (reset) begin
            buf_data[0] <= '0;
            buf_data[1] <= '0;
            buf_last    <= 2'b00;
            head        <= 1'b0;
            tail        <= 1'b0;
            occ         <= 2'd0;
        end else begin
            if (push) begin
                buf_data[tail] <= fifo_data;
                buf_last[tail] <= (beat_cnt == LAST_BEAT);
                tail           <= ~tail;
            end
            if (pop) begin
                head <= ~head;
            end
            unique case ({push, pop})
                2'b10:   occ <= occ + 2'd1;
                2'b01:   occ <= occ - 2'd1;
                default: occ <= occ;
            endcase
        end
    end

    // Burst position; survives enable drops so framing resumes in place.
    always_ff @(posedge clk) begin
        if (reset) begin
            beat_cnt <= '0;
        end else if (push) begin
            if (beat_cnt == LAST_BEAT) begin
                beat_cnt <= '0;
            end else begin
                beat_cnt <= beat_cnt + 1'b1;
            end
        end
    end

`ifdef FIFO_DRAIN_CNT_EN
    // Saturating count of words accepted downstream.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_count <= '0;
        end else if (pop && (rd_count != {CNT_W{1'b1}})) begin
            rd_count <= rd_count + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_fifo_drain_ctrl.sv
// tb_fifo_drain_ctrl: directed self-checking bench for fifo_drain_ctrl.
// Models a registered-output FIFO and a stream sink monitor.

module tb_fifo_drain_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic       fifo_empty;
    logic [7:0] fifo_data = 8'h00;
    logic       fifo_rd;
    logic [7:0] m_data;
    logic       m_valid;
    logic       m_last;
    logic       m_ready;
    logic       busy;
`ifdef FIFO_DRAIN_CNT_EN
    logic [1:0] rd_count;
`endif

    fifo_drain_ctrl #(
        .WIDTH(8),
        .BURST(4),
        .CNT_W(2)
    ) dut (
        .clk(clk),
        .reset(reset),
        .enable(enable),
        .fifo_empty(fifo_empty),
        .fifo_data(fifo_data),
        .fifo_rd(fifo_rd),
        .m_data(m_data),
        .m_valid(m_valid),
        .m_last(m_last),
        .m_ready(m_ready),
        .busy(busy)
`ifdef FIFO_DRAIN_CNT_EN
        ,
        .rd_count(rd_count)
`endif
    );

    always #5 clk = ~clk;

    // FIFO model: data registered one cycle after the read strobe.
    logic [7:0] fmem [64];
    int         wr_ptr = 0;
    int         rd_ptr = 0;
    logic       rd_seen = 1'b0;
    int         empty_rd = 0;

    assign fifo_empty = (wr_ptr == rd_ptr);

    always @(negedge clk) rd_seen <= fifo_rd;

    always @(posedge clk) begin
        if (reset) begin
            rd_ptr    <= wr_ptr;
            fifo_data <= 8'h00;
        end else if (rd_seen) begin
            if (wr_ptr == rd_ptr) begin
                empty_rd <= empty_rd + 1;
            end else begin
                fifo_data <= fmem[rd_ptr % 64];
                rd_ptr    <= rd_ptr + 1;
            end
        end
    end

    // Sink monitor: records read pulses, accepted words, hold violations.
    int         cyc = 0;
    int         n_rd = 0;
    int         n_got = 0;
    int         rd_cyc [256];
    logic [7:0] got_d [256];
    logic       got_l [256];
    int         got_cyc [256];
    int         stab_err = 0;
    logic       pv = 1'b0;
    logic       pr = 1'b0;
    logic       pl = 1'b0;
    logic       prst = 1'b0;
    logic [7:0] pd = 8'h00;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (fifo_rd) begin
            rd_cyc[n_rd] <= cyc;
            n_rd         <= n_rd + 1;
        end
        if (m_valid && m_ready) begin
            got_d[n_got]   <= m_data;
            got_l[n_got]   <= m_last;
            got_cyc[n_got] <= cyc;
            n_got          <= n_got + 1;
        end
        if (pv && !pr && !reset && !prst) begin
            if (!m_valid || m_data != pd || m_last != pl)
                stab_err <= stab_err + 1;
        end
        pv   <= m_valid;
        pr   <= m_ready;
        pd   <= m_data;
        pl   <= m_last;
        prst <= reset;
    end

    int total = 0;
    int bad = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", nm, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push(input logic [7:0] v);
        fmem[wr_ptr % 64] = v;
        wr_ptr = wr_ptr + 1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        tick(1);
    endtask

    task automatic wait_got(input int target, input int limit,
                            input string nm);
        int k;
        k = 0;
        while (n_got < target && k < limit) begin
            tick(1);
            k++;
        end
        chk(nm, n_got, target);
    endtask

    typedef struct {
        logic [7:0] din;
        logic       last;
    } vec_t;

    vec_t burst_v [8];
    int   bg;
    int   br;
    int   gap_ok;
    int   seen;

    initial begin
        burst_v[0] = '{din: 8'h01, last: 1'b0};
        burst_v[1] = '{din: 8'h02, last: 1'b0};
        burst_v[2] = '{din: 8'h03, last: 1'b0};
        burst_v[3] = '{din: 8'h04, last: 1'b1};
        burst_v[4] = '{din: 8'h05, last: 1'b0};
        burst_v[5] = '{din: 8'h06, last: 1'b0};
        burst_v[6] = '{din: 8'h07, last: 1'b0};
        burst_v[7] = '{din: 8'h08, last: 1'b1};

        enable  = 1'b0;
        m_ready = 1'b0;
        reset   = 1'b1;
        tick(3);
        chk("rst_fifo_rd", fifo_rd, 0);
        chk("rst_m_valid", m_valid, 0);
        chk("rst_m_last", m_last, 0);
        chk("rst_busy", busy, 0);
        chk("rst_m_data", m_data, 0);
`ifdef FIFO_DRAIN_CNT_EN
        chk("rst_rd_count", rd_count, 0);
`endif
        reset = 1'b0;
        tick(1);

        // single word
        bg = n_got;
        br = n_rd;
        push(8'hA5);
        m_ready = 1'b1;
        enable  = 1'b1;
        wait_got(bg + 1, 50, "single_cnt");
        tick(20);
        chk("single_rd_pulses", n_rd - br, 1);
        chk("single_data", got_d[bg], 8'hA5);
        chk("single_last", got_l[bg], 0);
        chk("single_latency", got_cyc[bg] - rd_cyc[br], 2);

        // burst framing, table driven
        enable = 1'b0;
        do_reset();
        bg = n_got;
        br = n_rd;
        for (int i = 0; i < 8; i++) push(burst_v[i].din);
        enable = 1'b1;
        wait_got(bg + 8, 200, "burst_cnt");
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("burst_data%0d", i), got_d[bg + i], burst_v[i].din);
            chk($sformatf("burst_last%0d", i), got_l[bg + i], burst_v[i].last);
        end
        chk("burst_rd_pulses", n_rd - br, 8);
        gap_ok = 1;
        for (int i = 1; i < 8; i++)
            if (rd_cyc[br + i] - rd_cyc[br + i - 1] < 4) gap_ok = 0;
        chk("burst_rd_gap", gap_ok, 1);

        // backpressure
        enable  = 1'b0;
        m_ready = 1'b0;
        do_reset();
        bg = n_got;
        br = n_rd;
        for (int i = 0; i < 5; i++) push(8'h11 + 8'(i));
        enable = 1'b1;
        tick(40);
        chk("bp_rd_pulses", n_rd - br, 2);
        chk("bp_m_valid", m_valid, 1);
        chk("bp_m_data", m_data, 8'h11);
        chk("bp_busy", busy, 1);
        chk("bp_fifo_rd", fifo_rd, 0);
        chk("bp_none_taken", n_got - bg, 0);
        m_ready = 1'b1;
        wait_got(bg + 5, 100, "bp_cnt");
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("bp_data%0d", i), got_d[bg + i], 8'h11 + i);
            chk($sformatf("bp_last%0d", i), got_l[bg + i], (i == 3) ? 1 : 0);
        end
        chk("bp_rd_total", n_rd - br, 5);
        chk("bp_stable", stab_err, 0);

        // empty FIFO, then enable drop during ISSUE
        enable = 1'b0;
        do_reset();
        bg = n_got;
        br = n_rd;
        enable = 1'b1;
        tick(100);
        chk("empty_rd_pulses", n_rd - br, 0);
        chk("empty_busy", busy, 0);
        chk("empty_m_valid", m_valid, 0);
        for (int i = 0; i < 4; i++) push(8'h21 + 8'(i));
        for (int k = 0; k < 20; k++) begin
            tick(1);
            if (fifo_rd) break;
        end
        enable = 1'b0;
        tick(40);
        chk("drop_rd_pulses", n_rd - br, 1);
        chk("drop_delivered", n_got - bg, 1);
        chk("drop_data", got_d[bg], 8'h21);
        chk("drop_last", got_l[bg], 0);
        chk("drop_idle_busy", busy, 0);
        enable = 1'b1;
        wait_got(bg + 4, 100, "resume_cnt");
        for (int i = 1; i < 4; i++) begin
            chk($sformatf("resume_data%0d", i), got_d[bg + i], 8'h21 + i);
            chk($sformatf("resume_last%0d", i), got_l[bg + i], (i == 3) ? 1 : 0);
        end
        chk("resume_rd_total", n_rd - br, 4);

        // reset mid-stream, in LATCH with a word buffered
        enable  = 1'b0;
        m_ready = 1'b0;
        do_reset();
        for (int i = 0; i < 3; i++) push(8'h31 + 8'(i));
        enable = 1'b1;
        seen = 0;
        for (int k = 0; k < 40 && seen < 2; k++) begin
            tick(1);
            if (fifo_rd) seen++;
        end
        chk("mid_two_reads", seen, 2);
        tick(1);
        chk("mid_pre_valid", m_valid, 1);
        reset = 1'b1;
        tick(1);
        chk("mid_m_valid", m_valid, 0);
        chk("mid_fifo_rd", fifo_rd, 0);
        chk("mid_busy", busy, 0);
        chk("mid_m_data", m_data, 0);
`ifdef FIFO_DRAIN_CNT_EN
        chk("mid_rd_count", rd_count, 0);
`endif
        enable = 1'b0;
        reset  = 1'b0;
        tick(2);

`ifdef FIFO_DRAIN_CNT_EN
        do_reset();
        bg = n_got;
        m_ready = 1'b1;
        for (int i = 0; i < 5; i++) push(8'h41 + 8'(i));
        enable = 1'b1;
        wait_got(bg + 5, 100, "cnt_words");
        tick(2);
        chk("cnt_saturated", rd_count, 3);
        enable = 1'b0;
`endif

        chk("no_empty_reads", empty_rd, 0);
        chk("hold_stable", stab_err, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
